// File: rtl/loop_pkg.sv
// Shared types for the loop sequencer: FSM state encoding, rate level type
// and the default rate magnitude limit.
package loop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } loop_state_t;

  localparam int RATE_MAX_DEF = 3;

  // Signed playback rate level; holds -RATE_MAX..+RATE_MAX.
  typedef logic signed [2:0] rate_t;

endpackage

// File: rtl/loop_addr_gen.sv
// Combinational next play pointer: advances ptr by step around a loop of
// loop_len samples, forward or (reverse=1) descending. The step is first
// folded below loop_len so that a single wrap always lands in range, even
// for very short loops.
module loop_addr_gen #(
  parameter int ADDR_W   = 16,
  parameter int STEP_MAX = 4
) (
  input  logic [ADDR_W:0] ptr,
  input  logic [ADDR_W:0] step,
  input  logic [ADDR_W:0] loop_len,
  input  logic            reverse,
  output logic [ADDR_W:0] next_ptr
);

  logic [ADDR_W:0]   step_r;
  logic [ADDR_W+1:0] sum;

  // Fold the step, then apply one forward or backward wrap.
  always_comb begin
    step_r = step;
    for (int i = 0; i < STEP_MAX; i++) begin
      if (loop_len != '0 && step_r >= loop_len) step_r = step_r - loop_len;
    end
    sum      = {1'b0, ptr} + {1'b0, step_r};
    next_ptr = '0;
    if (loop_len == '0) begin
      next_ptr = '0;
    end else if (!reverse) begin
      if (sum >= {1'b0, loop_len}) next_ptr = (ADDR_W+1)'(sum - {1'b0, loop_len});
      else                         next_ptr = sum[ADDR_W:0];
    end else begin
      if (ptr < step_r) next_ptr = ptr + loop_len - step_r;
      else              next_ptr = ptr - step_r;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Loop sequencer: records codec samples into loop memory, then plays them
// back at an adjustable rate and direction.
// Optional feature macro: LOOP_SEQ_RATE_EN (signed rate control with
// speed_up/slow_down; when undefined playback always steps by one).
//
// Codec handshake: a sample tick occurs in any cycle where codec_read_ready
// and codec_write_ready are both high; codec_read and codec_write then pulse
// together for exactly one cycle, the cycle after the tick, and never otherwise.
module loop_sequencer
  import loop_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int RATE_MAX = RATE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_btn,
  input  logic              speed_up,
  input  logic              slow_down,
  input  logic              reverse,
  input  logic              codec_read_ready,
  input  logic              codec_write_ready,
  output logic              codec_read,
  output logic              codec_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              play_src,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   loop_len,
  output logic signed [2:0] rate
);

  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  loop_state_t       state_q, state_d;
  logic              tick;
  logic [ADDR_W:0]   ptr_q, ptr_d;   // sample count in RECORD, play pointer in PLAY
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              strobe_q, we_q;
  logic [ADDR_W:0]   step;
  logic              advance;
  logic [ADDR_W:0]   ptr_adv;
  rate_t             rate_q;

  assign tick = codec_read_ready & codec_write_ready;

`ifdef LOOP_SEQ_RATE_EN
  rate_t      rate_d;
  logic [1:0] hold_q, hold_d;
  logic [1:0] hold_lim;

  // Saturating rate level; simultaneous up and down cancel.
  always_comb begin
    rate_d = rate_q;
    if (speed_up && !slow_down && rate_q < rate_t'(RATE_MAX))
      rate_d = rate_q + 3'sd1;
    else if (slow_down && !speed_up && rate_q > -rate_t'(RATE_MAX))
      rate_d = rate_q - 3'sd1;
  end

  // Negative rates hold each address for |r|+1 ticks.
  assign hold_lim = 2'(-rate_q);
  assign step     = rate_q[2] ? ONE : (ADDR_W+1)'(rate_q[1:0]) + ONE;
  assign advance  = !rate_q[2] || (hold_q == hold_lim);

  // Hold counter: counts ticks in PLAY at negative rates, cleared on rate change.
  always_comb begin
    hold_d = hold_q;
    if (state_q != PLAY)       hold_d = '0;
    else if (tick && rate_q[2]) hold_d = (hold_q == hold_lim) ? 2'd0 : hold_q + 2'd1;
    if (rate_d != rate_q)      hold_d = '0;
  end

  // Rate level and hold counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q <= '0;
      hold_q <= '0;
    end else begin
      rate_q <= rate_d;
      hold_q <= hold_d;
    end
  end
`else
  logic rate_unused;
  assign rate_unused = ^{speed_up, slow_down};
  assign rate_q      = '0;
  assign step        = ONE;
  assign advance     = 1'b1;
`endif

  loop_addr_gen #(
    .ADDR_W   (ADDR_W),
    .STEP_MAX (RATE_MAX + 1)
  ) u_addr_gen (
    .ptr      (ptr_q),
    .step     (step),
    .loop_len (len_q),
    .reverse  (reverse),
    .next_ptr (ptr_adv)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a tick in the same cycle as rec_btn still counts as a sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rec_btn) state_d = RECORD;
      RECORD: begin
        if (tick && ptr_q == LAST) state_d = PLAY;
        else if (rec_btn)          state_d = (ptr_q != '0 || tick) ? PLAY : IDLE;
      end
      PLAY:    if (rec_btn) state_d = RECORD;
      default: state_d = IDLE;
    endcase
  end

  // Pointer and loop length update.
  always_comb begin
    ptr_d = ptr_q;
    len_d = len_q;
    case (state_q)
      RECORD: begin
        if (tick) ptr_d = ptr_q + ONE;
        if (state_d == PLAY) begin
          len_d = tick ? ptr_q + ONE : ptr_q;
          ptr_d = reverse ? len_d - ONE : '0;
        end else if (state_d == IDLE) begin
          ptr_d = '0;
        end
      end
      PLAY: begin
        if (tick && advance) ptr_d = ptr_adv;
        if (state_d == RECORD) ptr_d = '0;
      end
      default: ptr_d = '0;
    endcase
  end

  // Datapath registers and the one-cycle-delayed codec/memory strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      len_q     <= '0;
      wr_addr_q <= '0;
      strobe_q  <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      strobe_q <= tick;
      we_q     <= tick && (state_q == RECORD);
      if (tick && state_q == RECORD) wr_addr_q <= ptr_q[ADDR_W-1:0];
    end
  end

  assign codec_read  = strobe_q;
  assign codec_write = strobe_q;
  assign mem_we      = we_q;
  assign play_src    = (state_q == PLAY);
  assign mem_addr    = we_q ? wr_addr_q : ((state_q == PLAY) ? ptr_q[ADDR_W-1:0] : '0);
  assign state       = state_q;
  assign loop_len    = len_q;
  assign rate        = rate_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer (ADDR_W=4): directed scenarios then random
// stimulus, every cycle compared against a behavioural model.
module tb_loop_sequencer;

  localparam int ADDR_W   = 4;
  localparam int LEN_FULL = 1 << ADDR_W;
  localparam int RMAX     = 3;
`ifdef LOOP_SEQ_RATE_EN
  localparam bit RATE_EN = 1'b1;
`else
  localparam bit RATE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rec_btn = 1'b0, speed_up = 1'b0, slow_down = 1'b0, reverse = 1'b0;
  logic              codec_read_ready = 1'b0, codec_write_ready = 1'b0;
  logic              codec_read, codec_write, mem_we, play_src;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        state;
  logic [ADDR_W:0]   loop_len;
  logic signed [2:0] rate;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: mode 0/1/2 = idle/record/play.
  int m_mode, m_cnt, m_len, m_pos, m_rate, m_since, m_waddr;
  bit m_we, m_tick;

  // Clock/reset block.
  always #5 clk = ~clk;

  loop_sequencer #(.ADDR_W(ADDR_W), .RATE_MAX(RMAX)) dut (
    .clk               (clk),
    .reset             (reset),
    .rec_btn           (rec_btn),
    .speed_up          (speed_up),
    .slow_down         (slow_down),
    .reverse           (reverse),
    .codec_read_ready  (codec_read_ready),
    .codec_write_ready (codec_write_ready),
    .codec_read        (codec_read),
    .codec_write       (codec_write),
    .mem_addr          (mem_addr),
    .mem_we            (mem_we),
    .play_src          (play_src),
    .state             (state),
    .loop_len          (loop_len),
    .rate              (rate)
  );

  task automatic check(string tag, int obs, int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wrap(int p, int s, bit rv, int len);
    if (rv) return ((p - s) % len + len) % len;
    return (p + s) % len;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_len = 0; m_pos = 0; m_rate = 0; m_since = 0;
    m_waddr = 0; m_we = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_step(bit rec, bit su, bit sd, bit rv, bit tk);
    int nr;
    m_we = 1'b0;
    case (m_mode)
      0: if (rec) begin m_mode = 1; m_cnt = 0; end
      1: begin
        if (tk) begin m_we = 1'b1; m_waddr = m_cnt; m_cnt++; end
        if (m_cnt == LEN_FULL || (rec && m_cnt > 0)) begin
          m_mode = 2; m_len = m_cnt; m_pos = rv ? m_len - 1 : 0; m_since = 0;
        end else if (rec) begin
          m_mode = 0;
        end
      end
      default: begin
        if (tk) begin
          if (m_rate >= 0) m_pos = wrap(m_pos, m_rate + 1, rv, m_len);
          else begin
            m_since++;
            if (m_since == 1 - m_rate) begin m_pos = wrap(m_pos, 1, rv, m_len); m_since = 0; end
          end
        end
        if (rec) begin m_mode = 1; m_cnt = 0; end
      end
    endcase
    if (RATE_EN) begin
      nr = m_rate;
      if (su && !sd) nr++;
      if (sd && !su) nr--;
      if (nr > RMAX) nr = RMAX;
      if (nr < -RMAX) nr = -RMAX;
      if (nr != m_rate) begin m_rate = nr; m_since = 0; end
    end
    m_tick = tk;
  endtask

  task automatic compare_all();
    check("state", int'(state), m_mode);
    check("loop_len", int'(loop_len), m_len);
    check("rate", int'(rate), m_rate);
    check("play_src", int'(play_src), int'(m_mode == 2));
    check("mem_we", int'(mem_we), int'(m_we));
    check("mem_addr", int'(mem_addr), m_we ? m_waddr : (m_mode == 2 ? m_pos : 0));
    check("codec_read", int'(codec_read), int'(m_tick));
    check("codec_write", int'(codec_write), int'(m_tick));
  endtask

  // Driver: apply one cycle of inputs (called at a falling edge).
  task automatic cyc(bit rec, bit su, bit sd, bit rv, bit rr, bit wr);
    rec_btn = rec; speed_up = su; slow_down = sd; reverse = rv;
    codec_read_ready = rr; codec_write_ready = wr;
    @(posedge clk);
    model_step(rec, su, sd, rv, rr && wr);
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic ticks(int n, bit rv);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, rv, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, rv, 1'b0, 1'b0);
    end
  endtask

  task automatic press(bit rec, bit su, bit sd);
    cyc(rec, su, sd, reverse, 1'b0, 1'b0);
  endtask

  initial begin
    bit rv_r;
    model_reset();
    @(negedge clk);
    #1 compare_all();
    reset = 1'b1;
    @(negedge clk);

    // Record five samples, then play.
    press(1'b1, 1'b0, 1'b0);
    ticks(5, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("len_after_5", int'(loop_len), 5);
    check("state_play", int'(state), 2);

    // Plain playback, then reverse, then half-ready (no tick).
    ticks(7, 1'b0);
    ticks(3, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Rate changes: up twice, saturate, both at once, down five.
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    ticks(5, 1'b0);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b0, 1'b1);
    ticks(9, 1'b0);
    for (int i = 0; i < 2; i++) press(1'b0, 1'b1, 1'b0);

    // Full-depth recording forces playback.
    press(1'b1, 1'b0, 1'b0);
    ticks(LEN_FULL, 1'b0);
    check("full_len", int'(loop_len), LEN_FULL);
    check("full_state", int'(state), 2);
    ticks(4, 1'b1);

    // Re-record with zero samples returns to idle, loop_len retained.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("empty_idle", int'(state), 0);

    // rec_btn together with a tick at pointer 3.
    press(1'b1, 1'b0, 1'b0);
    ticks(3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("coinc_we", int'(mem_we), 1);
    check("coinc_addr", int'(mem_addr), 3);
    check("coinc_len", int'(loop_len), 4);
    ticks(3, 1'b0);

    // Asynchronous reset in the middle of a recording write.
    press(1'b1, 1'b0, 1'b0);
    ticks(2, 1'b0);
    rec_btn = 1'b0; codec_read_ready = 1'b1; codec_write_ready = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_we", int'(mem_we), 0);
    check("rst_len", int'(loop_len), 0);
    compare_all();
    @(negedge clk);
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    rv_r = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) rv_r = ~rv_r;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 19) == 0, rv_r,
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
